// File: rtl/fe_capture_multi.sv
// fe_capture_multi: round-robin multi-channel front-end event capture with delta timestamps.
// Define FE_CAPTURE_DROP_COUNT_EN to implement the saturating lost-event counter.
`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 2'b10
`endif

module fe_capture_multi #(
    parameter int pCHANNELS          = 4,
    parameter int pTIMESTAMP_WIDTH   = 16,
    parameter int pCAPTURE_LEN_WIDTH = 24,
    parameter int pCH_WIDTH          = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1
) (
    input  logic                          fe_clk,
    input  logic                          reset_i,
    input  logic [pCHANNELS-1:0]          I_event,
    input  logic [2*pCHANNELS-1:0]        I_data_cmd,
    input  logic                          I_arm,
    input  logic                          I_capture_enable,
    input  logic [pCAPTURE_LEN_WIDTH-1:0] I_capture_len,
    input  logic [pTIMESTAMP_WIDTH-1:0]   I_max_timestamp,
    input  logic                          I_timestamps_disable,
    input  logic                          I_fifo_full,
    output logic                          O_fifo_wr,
    output logic [1:0]                    O_fifo_command,
    output logic [pCH_WIDTH-1:0]          O_fifo_channel,
    output logic [pTIMESTAMP_WIDTH-1:0]   O_fifo_time,
    output logic                          O_capturing,
    output logic                          O_capture_done,
    output logic [15:0]                   O_dropped_count
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic                            arm_q;
    logic [pCHANNELS-1:0]            event_q, event_d;
    logic [2*pCHANNELS-1:0]          cmd_in_q;
    logic [pCHANNELS-1:0]            pending_q, pending_d;
    logic [2*pCHANNELS-1:0]          cmd_q, cmd_d;
    logic [pCH_WIDTH-1:0]            last_q, last_d;
    logic [pCAPTURE_LEN_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [pTIMESTAMP_WIDTH-1:0]     ts_q, ts_d;
    logic                            wr_q, wr_d;
    logic [1:0]                      fcmd_q, fcmd_d;
    logic [pCH_WIDTH-1:0]            chan_q, chan_d;
    logic [pTIMESTAMP_WIDTH-1:0]     time_q, time_d;
    logic                            capturing_q, capturing_d;
    logic                            done_q, done_d;

    logic                 capturing, arm_rise, len_hit, can_write;
    logic                 grant_vld, data_wr, time_wr, any_wr;
    logic [pCH_WIDTH-1:0] grant_idx;
    logic [pCHANNELS-1:0] gnt, blocked;

    // Round-robin search starting one past the last granted channel
    always_comb begin : arb
        int k;
        logic [pCH_WIDTH-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        k = 0;
        idx = '0;
        for (int i = 1; i <= pCHANNELS; i++) begin
            k = int'(last_q) + i;
            if (k >= pCHANNELS) k = k - pCHANNELS;
            idx = pCH_WIDTH'(k);
            if (!grant_vld && pending_q[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        capturing = (state_q == S_CAPTURE);
        arm_rise  = I_arm && !arm_q;
        len_hit   = (I_capture_len != '0) && (wr_cnt_q >= I_capture_len);
        can_write = capturing && !I_fifo_full && !len_hit;
        data_wr   = can_write && grant_vld;
        time_wr   = can_write && !grant_vld && !I_timestamps_disable
                    && (ts_q == I_max_timestamp);
        any_wr    = data_wr || time_wr;

        gnt = '0;
        if (data_wr) gnt[grant_idx] = 1'b1;
        blocked = pending_q & ~gnt;

        event_d   = capturing ? I_event : '0;
        pending_d = pending_q;
        cmd_d     = cmd_q;
        last_d    = last_q;
        wr_cnt_d  = wr_cnt_q;
        ts_d      = ts_q;

        if (state_q == S_ARMED) begin
            pending_d = '0;
            last_d    = pCH_WIDTH'(pCHANNELS - 1);
            wr_cnt_d  = '0;
            ts_d      = pTIMESTAMP_WIDTH'(1);
        end else if (capturing) begin
            pending_d = blocked | event_q;
            for (int n = 0; n < pCHANNELS; n++) begin
                if (event_q[n] && !blocked[n]) cmd_d[2*n +: 2] = cmd_in_q[2*n +: 2];
            end
            if (data_wr) last_d = grant_idx;
            if (any_wr) begin
                wr_cnt_d = wr_cnt_q + pCAPTURE_LEN_WIDTH'(1);
                ts_d     = pTIMESTAMP_WIDTH'(1);
            end else if (ts_q < I_max_timestamp) begin
                ts_d = ts_q + pTIMESTAMP_WIDTH'(1);
            end
        end

        state_d = state_q;
        case (state_q)
            S_ARMED:   if (I_capture_enable) state_d = S_CAPTURE;
            S_CAPTURE: if (!I_capture_enable ||
                           ((I_capture_len != '0) && (wr_cnt_d >= I_capture_len)))
                           state_d = S_DONE;
            S_DONE:    if (!I_arm) state_d = S_IDLE;
            default:   state_d = state_q;
        endcase
        if (arm_rise) state_d = S_ARMED;

        wr_d   = any_wr;
        fcmd_d = data_wr ? cmd_q[{grant_idx, 1'b0} +: 2]
               : (time_wr ? `FE_FIFO_CMD_TIME : 2'b00);
        chan_d = data_wr ? grant_idx : '0;
        time_d = (any_wr && !I_timestamps_disable) ? ts_q : '0;

        capturing_d = capturing;
        done_d      = (state_q == S_IDLE) || (state_q == S_DONE);
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            arm_q       <= 1'b0;
            event_q     <= '0;
            cmd_in_q    <= '0;
            pending_q   <= '0;
            cmd_q       <= '0;
            last_q      <= pCH_WIDTH'(pCHANNELS - 1);
            wr_cnt_q    <= '0;
            ts_q        <= pTIMESTAMP_WIDTH'(1);
            wr_q        <= 1'b0;
            fcmd_q      <= '0;
            chan_q      <= '0;
            time_q      <= '0;
            capturing_q <= 1'b0;
            done_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            arm_q       <= I_arm;
            event_q     <= event_d;
            cmd_in_q    <= I_data_cmd;
            pending_q   <= pending_d;
            cmd_q       <= cmd_d;
            last_q      <= last_d;
            wr_cnt_q    <= wr_cnt_d;
            ts_q        <= ts_d;
            wr_q        <= wr_d;
            fcmd_q      <= fcmd_d;
            chan_q      <= chan_d;
            time_q      <= time_d;
            capturing_q <= capturing_d;
            done_q      <= done_d;
        end
    end

`ifdef FE_CAPTURE_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Several channels can lose an event in the same cycle
    always_comb begin : drop_sum
        logic [16:0] sum;
        sum = {1'b0, drop_cnt_q};
        for (int n = 0; n < pCHANNELS; n++) begin
            sum = sum + 17'(capturing && event_q[n] && blocked[n]);
        end
        if (state_q == S_ARMED) drop_cnt_d = '0;
        else                    drop_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_cnt_d;
    end

    assign O_dropped_count = drop_cnt_q;
`else
    assign O_dropped_count = '0;
`endif

    assign O_fifo_wr      = wr_q;
    assign O_fifo_command = fcmd_q;
    assign O_fifo_channel = chan_q;
    assign O_fifo_time    = time_q;
    assign O_capturing    = capturing_q;
    assign O_capture_done = done_q;

endmodule
